icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, read-only instruction cache between the fetch stage and memory_control.
//  Serves imemREN/imemaddr lookups with a zero-cycle hit. On a miss it fills a 2-word
//  block through the iREN/iaddr/iwait/iload port of memory_control.
//  The flush input invalidates every line (halt / self-modifying-code support).
// PARAMETERS
//  SETS    8    number of lines; power of 2; index = imemaddr[2+log2(SETS):3]
//  WORDS   2    words per block; fixed at 2 in this revision (word select = addr[2])
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  nRST       in   1   reset; synchronous, active-low
//  imemREN    in   1   fetch request from datapath
//  imemaddr   in   32  byte address of fetch; bits [1:0] ignored
//  flush      in   1   invalidate all lines
//  ihit       out  1   imemload valid this cycle
//  imemload   out  32  instruction word returned to datapath
//  iREN       out  1   read request to memory_control
//  iaddr      out  32  word address to memory_control
//  iwait      in   1   memory_control stall; 0 = iload valid this cycle
//  iload      in   32  read data from memory_control
// BEHAVIOUR
//  Address split: tag=[31:6], index=[5:3], word=[2], byte=[1:0] (SETS=8).
//  Per-line state: valid(1), tag(26), data[2](32 each).
//  Reset (nRST=0 at an edge): state->IDLE, every valid->0, fill regs->0, flush_pend->0.
//  Reset values while nRST=0: ihit=0, iREN=0, iaddr=0, imemload=0.
//  FSM states: IDLE, FILL0, FILL1.
//  IDLE behaviour:
//   - hit = imemREN & valid[idx] & tag match & !flush.
//   - ihit=hit, combinationally in the same cycle; imemload=data[idx][word] on a hit, else 0.
//   - iREN=0, iaddr=0.
//   - imemREN & !hit & !flush: latch fill_addr={tag,idx,3'b000}, go to FILL0.
//   - flush=1: clear all valid in 1 cycle, stay in IDLE; a miss in the same cycle is ignored.
//  FILL0 behaviour:
//   - iREN=1, iaddr=fill_addr, ihit=0.
//   - iwait=0: write iload into data[idx][0], go to FILL1; iwait=1: hold.
//  FILL1 behaviour:
//   - iREN=1, iaddr=fill_addr+4, ihit=0.
//   - iwait=0: write data[idx][1], write tag[idx], set valid[idx]=1, go to IDLE.
//  Miss latency: 1 lookup cycle + both RAM accesses + 1 re-lookup cycle that hits.
//  Fills always use the latched fill_addr and always complete, even if imemaddr changes
//   or imemREN drops mid-fill; the RAM transaction is never abandoned.
//  Replacement: a fill overwrites the indexed line unconditionally (valid or not).
//  flush during FILL0/FILL1: set flush_pend. The fill still completes (iREN held), but on
//   the FILL1 exit edge all valid bits clear, including the line just filled.
//   flush_pend clears on that same edge.
//  Back-to-back misses to the same index: the second fill replaces the first; no conflict.
//  iaddr bits [1:0] are always 0. No write port; instruction memory is read-only here.
//  nRST=0 mid-fill: abort at that edge, go to IDLE, clear valid. A partial line is never valid.
// TESTING
//  1 Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, RAM 2 wait cycles/word ->
//    iREN=1 with iaddr 0x40 then 0x44; ihit=1 with imemload=word@0x40 on cycle after FILL1.
//  2 Spatial hit: after 1, imemaddr=0x0000_0044 -> ihit=1 same cycle, iREN stays 0.
//  3 Conflict: fetch 0x40, then 0x240 (same index 0, different tag) -> miss and refill at
//    0x240/0x244; re-fetch of 0x40 then misses again.
//  4 Mid-fill address change: miss on 0x80, change imemaddr to 0x100 during FILL0 ->
//    iaddr stays 0x80/0x84; line 0 valid with tag of 0x80; 0x100 then misses.
//  5 Flush: fill 0x40, pulse flush 1 cycle in IDLE -> next fetch of 0x40 misses.
//    Flush during FILL1 -> fill completes, line invalid afterwards.
//  6 Reset mid-fill: nRST=0 during FILL0 with iwait=1 -> next edge iREN=0, state IDLE;
//    fetch of the same address misses again.

Source files
------------

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the fetch stage together with memory_control.
interface icache_direct_mapped_if;
  logic        imemren;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iren;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemren, imemaddr, flush, iwait, iload,
    output ihit, imemload, iren, iaddr
  );

  modport master (
    output imemren, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iren, iaddr
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with 2-word blocks.
// Hits return data in the same cycle. Misses fill the whole block from memory_control.
//
// state | meaning
// IDLE  | lookup; a hit returns data combinationally, a miss latches the block address
// FILL0 | reading word 0 of the block; held while iwait is high
// FILL1 | reading word 1; on completion the tag is written and the line is marked valid
module icache_direct_mapped #(
  parameter int SETS = 8
) (
  input logic               clk,
  input logic               nrst,
  icache_direct_mapped_if.slave bus
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 29 - IDXW;

  typedef enum logic [1:0] {IDLE, FILL0, FILL1} state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAGW-1:0]   tags  [SETS];
  logic [31:0]       data0 [SETS];
  logic [31:0]       data1 [SETS];
  logic [31:0]       fill_addr;
  logic              flush_pend;
  logic              iren_q;
  logic [31:0]       iaddr_q;

  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   fidx;
  logic [TAGW-1:0]   tag;
  logic              hit;

  assign idx  = bus.imemaddr[2+IDXW:3];
  assign tag  = bus.imemaddr[31:3+IDXW];
  assign fidx = fill_addr[2+IDXW:3];

  assign hit = nrst && (state == IDLE) && bus.imemren && !bus.flush
               && valid[idx] && (tags[idx] == tag);

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? (bus.imemaddr[2] ? data1[idx] : data0[idx]) : 32'h0;
  assign bus.iren     = iren_q & nrst;
  assign bus.iaddr    = nrst ? iaddr_q : 32'h0;

  // Line storage carries no reset; nothing is visible until valid is set.
  always_ff @(posedge clk) begin
    if (nrst && !bus.iwait) begin
      if (state == FILL0) begin
        data0[fidx] <= bus.iload;
      end
      if (state == FILL1) begin
        data1[fidx] <= bus.iload;
        tags[fidx]  <= fill_addr[31:3+IDXW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      valid      <= '0;
      fill_addr  <= 32'h0;
      flush_pend <= 1'b0;
      iren_q     <= 1'b0;
      iaddr_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (bus.imemren && !hit) begin
            fill_addr <= {bus.imemaddr[31:3], 3'b000};
            iaddr_q   <= {bus.imemaddr[31:3], 3'b000};
            iren_q    <= 1'b1;
            state     <= FILL0;
          end
        end
        FILL0: begin
          if (bus.flush) begin
            flush_pend <= 1'b1;
          end
          if (!bus.iwait) begin
            iaddr_q <= fill_addr + 32'd4;
            state   <= FILL1;
          end
        end
        FILL1: begin
          if (!bus.iwait) begin
            // A flush seen at any point during the fill wipes the freshly filled line too.
            if (flush_pend || bus.flush) begin
              valid <= '0;
            end else begin
              valid[fidx] <= 1'b1;
            end
            flush_pend <= 1'b0;
            iren_q     <= 1'b0;
            iaddr_q    <= 32'h0;
            state      <= IDLE;
          end else if (bus.flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: a block-level cache model checked against the DUT on every cycle,
// plus directed fetch sequences with hand-computed latencies and fill addresses.
module tb_icache_direct_mapped;
  logic clk = 1'b0;
  logic nrst;
  icache_direct_mapped_if bus ();

  icache_direct_mapped #(.SETS(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;
  int rw = 2;
  int rcnt = 0;
  logic [31:0] served[$];

  // model: block-level view of the cache contents and the outstanding fill
  bit          busy = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] base = 32'h0;
  int          words = 0;
  bit          mvalid [8];
  logic [25:0] mblk   [8];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    int i;
    i = int'(a[5:3]);
    return mvalid[i] && (mblk[i] == a[31:6]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!nrst) begin
      busy = 1'b0;
      pend = 1'b0;
      words = 0;
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    end else if (!busy) begin
      if (bus.flush) begin
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
      end else if (bus.imemren && !mhit(bus.imemaddr)) begin
        busy = 1'b1;
        base = {bus.imemaddr[31:3], 3'b000};
        words = 0;
      end
    end else begin
      if (bus.flush) pend = 1'b1;
      if (!bus.iwait) begin
        words++;
        if (words == 2) begin
          busy = 1'b0;
          if (pend) begin
            for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
          end else begin
            mvalid[int'(base[5:3])] = 1'b1;
            mblk[int'(base[5:3])] = base[31:6];
          end
          pend = 1'b0;
        end
      end
    end
  end

  // per-cycle compare, then the memory responder decides iwait/iload for the coming edge
  always @(negedge clk) begin
    logic        e_hit;
    logic [31:0] e_load;
    if (started) begin
      e_hit  = nrst && !busy && bus.imemren && !bus.flush && mhit(bus.imemaddr);
      e_load = e_hit ? memw({bus.imemaddr[31:2], 2'b00}) : 32'h0;
      chk("ihit",     {31'h0, bus.ihit}, {31'h0, e_hit});
      chk("imemload", bus.imemload, e_load);
      chk("iren",     {31'h0, bus.iren}, {31'h0, nrst && busy});
      chk("iaddr",    bus.iaddr, (nrst && busy) ? base + 32'(4 * words) : 32'h0);
    end
    if (bus.iren) begin
      if (rcnt < rw) begin
        bus.iwait = 1'b1;
        rcnt++;
      end else begin
        bus.iwait = 1'b0;
        bus.iload = memw(bus.iaddr);
        served.push_back(bus.iaddr);
        rcnt = 0;
      end
    end else begin
      bus.iwait = 1'b1;
      rcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] ld);
    bus.imemren = 1'b1;
    bus.imemaddr = a;
    lat = -1;
    ld = 32'h0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.ihit) begin
        lat = k;
        ld = bus.imemload;
        break;
      end
      step();
    end
    step();
    bus.imemren = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!bus.iren) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("idle_reached", {31'h0, ok}, 32'h1);
    step();
  endtask

  task automatic expect_fetch(input string nm, input logic [31:0] a, input int elat);
    int lat;
    logic [31:0] ld;
    fetch(a, lat, ld);
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_data"}, ld, memw(a));
  endtask

  initial begin
    nrst = 1'b0;
    bus.imemren = 1'b0;
    bus.imemaddr = 32'h0;
    bus.flush = 1'b0;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    @(posedge clk);
    started = 1'b1;
    #1;
    @(negedge clk);
    chk("reset_iren", {31'h0, bus.iren}, 32'h0);
    chk("reset_iaddr", bus.iaddr, 32'h0);
    step();
    nrst = 1'b1;
    step();

    // cold miss with 2 wait cycles per word: 1 + 3 + 3 cycles before the hit
    served.delete();
    expect_fetch("cold", 32'h40, 7);
    chk("cold_req_count", 32'(served.size()), 32'd2);
    if (served.size() == 2) begin
      chk("cold_addr0", served[0], 32'h40);
      chk("cold_addr1", served[1], 32'h44);
    end
    expect_fetch("spatial", 32'h44, 0);

    served.delete();
    expect_fetch("conflict", 32'h240, 7);
    if (served.size() == 2) begin
      chk("conflict_addr0", served[0], 32'h240);
      chk("conflict_addr1", served[1], 32'h244);
    end else chk("conflict_req_count", 32'(served.size()), 32'd2);
    expect_fetch("conflict_back", 32'h40, 7);

    // address changes in FILL0; fill still targets 0x80
    served.delete();
    bus.imemren = 1'b1;
    bus.imemaddr = 32'h80;
    step();
    step();
    bus.imemaddr = 32'h100;
    bus.imemren = 1'b0;
    wait_idle();
    if (served.size() == 2) begin
      chk("midfill_addr0", served[0], 32'h80);
      chk("midfill_addr1", served[1], 32'h84);
    end else chk("midfill_req_count", 32'(served.size()), 32'd2);
    expect_fetch("midfill_hit", 32'h80, 0);
    expect_fetch("midfill_other", 32'h100, 7);

    // flush in IDLE
    expect_fetch("flush_fill", 32'h40, 7);
    expect_fetch("flush_prehit", 32'h40, 0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    expect_fetch("flush_after", 32'h40, 7);

    // flush together with a miss: the miss is dropped
    bus.flush = 1'b1;
    bus.imemren = 1'b1;
    bus.imemaddr = 32'h50;
    step();
    bus.flush = 1'b0;
    bus.imemren = 1'b0;
    @(negedge clk);
    chk("flush_miss_ignored", {31'h0, bus.iren}, 32'h0);
    step();

    // flush during FILL1: fill completes, line invalid afterwards
    bus.imemren = 1'b1;
    bus.imemaddr = 32'h48;
    repeat (5) step();
    bus.flush = 1'b1;
    bus.imemren = 1'b0;
    step();
    bus.flush = 1'b0;
    wait_idle();
    expect_fetch("flush_fill1", 32'h48, 7);

    // reset during FILL0 while iwait is high
    bus.imemren = 1'b1;
    bus.imemaddr = 32'h88;
    step();
    step();
    nrst = 1'b0;
    bus.imemren = 1'b0;
    step();
    @(negedge clk);
    chk("rst_midfill_iren", {31'h0, bus.iren}, 32'h0);
    nrst = 1'b1;
    step();
    expect_fetch("rst_midfill_refetch", 32'h88, 7);
    expect_fetch("rst_flushed_line", 32'h48, 7);

    // zero-wait memory: 1 + 1 + 1 cycles
    rw = 0;
    expect_fetch("fast_miss", 32'h3F8, 3);
    expect_fetch("fast_hit", 32'h3FC, 0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
